// File: rtl/xrv1_imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter: the in-flight tag and
// the port identifiers it carries.
package xrv1_imem_arb_pkg;

   typedef struct packed {
      logic id;
      logic kill;
   } imem_tag_t;

   localparam logic PORT_IFETCH = 1'b0;
   localparam logic PORT_AUX    = 1'b1;

endpackage

// File: rtl/xrv1_imem_tag_fifo.sv
// In-order tag FIFO for requests in flight at the instruction memory.
// Same-cycle ordering is kill, then pop, then push.
module xrv1_imem_tag_fifo
   import xrv1_imem_arb_pkg::*;
#(
   parameter int depth_p = 2
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      push_i,
   input  imem_tag_t push_tag_i,
   input  logic      pop_i,
   input  logic      kill_i,
   input  logic      kill_id_i,
   output imem_tag_t head_o,
   output logic      empty_o
);

   localparam int ptr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1;

   imem_tag_t             mem_q [depth_p];
   logic [depth_p-1:0]    vld_q;
   logic [ptr_w_lp-1:0]   rd_ptr_q;
   logic [ptr_w_lp-1:0]   wr_ptr_q;

   function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(depth_p - 1)) ? '0 : p + ptr_w_lp'(1);
   endfunction

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = !vld_q[rd_ptr_q];

   // Later assignments win, so a push into the slot being popped (full
   // FIFO) leaves a fresh, unkilled entry.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vld_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         for (int i = 0; i < depth_p; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < depth_p; i++) begin
            if (kill_i && vld_q[i] && (mem_q[i].id == kill_id_i)) begin
               mem_q[i].kill <= 1'b1;
            end
         end
         if (pop_i) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= bump(rd_ptr_q);
         end
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_tag_i;
            vld_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q        <= bump(wr_ptr_q);
         end
      end
   end

endmodule

// File: rtl/xrv1_imem_arb.sv
// Round-robin arbiter for the single instruction-memory port with credit
// limiting, in-order response routing and port-0 redirect discard.
module xrv1_imem_arb
   import xrv1_imem_arb_pkg::*;
#(
   parameter int outst_p    = 2,
   parameter int outst_w_lp = $clog2(outst_p + 1)
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        p0_req_vld_i,
   output logic        p0_req_rdy_o,
   input  logic [31:0] p0_req_addr_i,
   input  logic        p0_flush_i,
   output logic        p0_resp_vld_o,
   output logic [31:0] p0_resp_data_o,
   input  logic        p1_req_vld_i,
   output logic        p1_req_rdy_o,
   input  logic [31:0] p1_req_addr_i,
   output logic        p1_resp_vld_o,
   output logic [31:0] p1_resp_data_o,
   output logic        mem_req_vld_o,
   input  logic        mem_req_rdy_i,
   output logic [31:0] mem_req_addr_o,
   input  logic        mem_resp_vld_i,
   input  logic [31:0] mem_resp_data_i
);

   logic [outst_w_lp-1:0] cnt_q;
   logic                  rr_q;
   logic                  credit;
   logic                  any_req;
   logic                  gnt1;
   logic                  accept;
   logic                  resp_pop;
   logic                  resp_live;
   logic                  fifo_empty;
   logic [31:0]           gnt_addr;
   imem_tag_t             head;
   imem_tag_t             push_tag;

   // A response in this cycle frees a slot, so a full counter still grants.
   assign credit   = (cnt_q < outst_w_lp'(outst_p)) | mem_resp_vld_i;
   assign any_req  = p0_req_vld_i | p1_req_vld_i;
   assign gnt1     = rr_q ? p1_req_vld_i : (p1_req_vld_i & !p0_req_vld_i);
   assign gnt_addr = gnt1 ? p1_req_addr_i : p0_req_addr_i;
   assign accept   = rst_ni & credit & any_req & mem_req_rdy_i;
   assign resp_pop = rst_ni & mem_resp_vld_i & !fifo_empty;
   assign push_tag = '{id: (gnt1 ? PORT_AUX : PORT_IFETCH), kill: 1'b0};

   assign mem_req_vld_o  = rst_ni & credit & any_req;
   assign mem_req_addr_o = rst_ni ? (gnt_addr & 32'hFFFF_FFFC) : '0;
   assign p0_req_rdy_o   = accept & !gnt1;
   assign p1_req_rdy_o   = accept & gnt1;

   assign resp_live      = resp_pop & !head.kill;
   assign p0_resp_vld_o  = resp_live & (head.id == PORT_IFETCH) & !p0_flush_i;
   assign p1_resp_vld_o  = resp_live & (head.id == PORT_AUX);
   assign p0_resp_data_o = rst_ni ? mem_resp_data_i : '0;
   assign p1_resp_data_o = rst_ni ? mem_resp_data_i : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         rr_q  <= PORT_IFETCH;
      end else begin
         if (accept && !resp_pop) begin
            cnt_q <= cnt_q + outst_w_lp'(1);
         end else if (!accept && resp_pop) begin
            cnt_q <= cnt_q - outst_w_lp'(1);
         end
         if (accept) begin
            rr_q <= !gnt1;
         end
      end
   end

   xrv1_imem_tag_fifo #(
      .depth_p (outst_p)
   ) u_tag_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (accept),
      .push_tag_i (push_tag),
      .pop_i      (resp_pop),
      .kill_i     (rst_ni & p0_flush_i),
      .kill_id_i  (PORT_IFETCH),
      .head_o     (head),
      .empty_o    (fifo_empty)
   );

endmodule

// File: tb/tb_xrv1_imem_arb.sv
// Self-checking bench for xrv1_imem_arb: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_xrv1_imem_arb;

   localparam int OUTST = 2;
   localparam logic [31:0] KEY = 32'h5A5A_0000;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        p0_req_vld_i = 1'b0;
   logic        p0_req_rdy_o;
   logic [31:0] p0_req_addr_i = '0;
   logic        p0_flush_i = 1'b0;
   logic        p0_resp_vld_o;
   logic [31:0] p0_resp_data_o;
   logic        p1_req_vld_i = 1'b0;
   logic        p1_req_rdy_o;
   logic [31:0] p1_req_addr_i = '0;
   logic        p1_resp_vld_o;
   logic [31:0] p1_resp_data_o;
   logic        mem_req_vld_o;
   logic        mem_req_rdy_i = 1'b0;
   logic [31:0] mem_req_addr_o;
   logic        mem_resp_vld_i = 1'b0;
   logic [31:0] mem_resp_data_i = '0;

   always #5 clk_i = ~clk_i;

   xrv1_imem_arb #(.outst_p(OUTST)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .p0_req_vld_i    (p0_req_vld_i),
      .p0_req_rdy_o    (p0_req_rdy_o),
      .p0_req_addr_i   (p0_req_addr_i),
      .p0_flush_i      (p0_flush_i),
      .p0_resp_vld_o   (p0_resp_vld_o),
      .p0_resp_data_o  (p0_resp_data_o),
      .p1_req_vld_i    (p1_req_vld_i),
      .p1_req_rdy_o    (p1_req_rdy_o),
      .p1_req_addr_i   (p1_req_addr_i),
      .p1_resp_vld_o   (p1_resp_vld_o),
      .p1_resp_data_o  (p1_resp_data_o),
      .mem_req_vld_o   (mem_req_vld_o),
      .mem_req_rdy_i   (mem_req_rdy_i),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_resp_vld_i  (mem_resp_vld_i),
      .mem_resp_data_i (mem_resp_data_i)
   );

   // Model: in-flight requests in issue order. A port-0 request remembers the
   // redirect epoch it was issued in; its response is wanted only if no
   // redirect has happened since.
   typedef struct {
      bit          id;
      int          epoch;
      logic [31:0] addr;
   } inflight_t;

   inflight_t   q[$];
   bit          pref;
   int          epoch;
   int          tests;
   int          fails;

   logic        r_mvld, r_rdy0, r_rdy1, r_resp0, r_resp1;
   logic [31:0] r_maddr, r_data0, r_data1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit v0, input logic [31:0] a0, input bit v1,
                        input logic [31:0] a1, input bit fl, input bit mrdy,
                        input bit resp_en);
      bit          resp, credit, g1, mvld, acc, want0;
      logic [31:0] eaddr;
      @(negedge clk_i);
      resp            = resp_en && (q.size() > 0);
      p0_req_vld_i    = v0;
      p0_req_addr_i   = a0;
      p1_req_vld_i    = v1;
      p1_req_addr_i   = a1;
      p0_flush_i      = fl;
      mem_req_rdy_i   = mrdy;
      mem_resp_vld_i  = resp;
      mem_resp_data_i = resp ? (q[0].addr ^ KEY) : $urandom;
      #1;
      credit = (q.size() < OUTST) || resp;
      g1     = pref ? v1 : (v1 && !v0);
      mvld   = credit && (v0 || v1);
      acc    = mvld && mrdy;
      eaddr  = (g1 ? a1 : a0) & 32'hFFFF_FFFC;
      chk("mem_req_vld", mem_req_vld_o, mvld);
      if (mvld) chk("mem_req_addr", mem_req_addr_o, eaddr);
      chk("p0_req_rdy", p0_req_rdy_o, acc && !g1);
      chk("p1_req_rdy", p1_req_rdy_o, acc && g1);
      if (resp) begin
         want0 = (q[0].id == 1'b0) && (q[0].epoch == epoch) && !fl;
         chk("p0_resp_vld", p0_resp_vld_o, want0);
         chk("p1_resp_vld", p1_resp_vld_o, q[0].id == 1'b1);
         chk("p0_resp_data", p0_resp_data_o, q[0].addr ^ KEY);
         chk("p1_resp_data", p1_resp_data_o, q[0].addr ^ KEY);
      end else begin
         chk("p0_resp_idle", p0_resp_vld_o, 1'b0);
         chk("p1_resp_idle", p1_resp_vld_o, 1'b0);
      end
      r_mvld  = mem_req_vld_o;
      r_maddr = mem_req_addr_o;
      r_rdy0  = p0_req_rdy_o;
      r_rdy1  = p1_req_rdy_o;
      r_resp0 = p0_resp_vld_o;
      r_resp1 = p1_resp_vld_o;
      r_data0 = p0_resp_data_o;
      r_data1 = p1_resp_data_o;
      @(posedge clk_i);
      if (fl) epoch++;
      if (resp) void'(q.pop_front());
      if (acc) begin
         q.push_back('{g1, epoch, eaddr});
         pref = !g1;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk_i);
      rst_ni          = 1'b0;
      p0_req_vld_i    = 1'b1;
      p1_req_vld_i    = 1'b1;
      p0_req_addr_i   = $urandom;
      p1_req_addr_i   = $urandom;
      p0_flush_i      = 1'b1;
      mem_req_rdy_i   = 1'b1;
      mem_resp_vld_i  = 1'b1;
      mem_resp_data_i = $urandom;
      for (int i = 0; i < n; i++) begin
         #1;
         chk("rst_mem_req_vld", mem_req_vld_o, 1'b0);
         chk("rst_mem_req_addr", mem_req_addr_o, 32'h0);
         chk("rst_req_rdy", {p0_req_rdy_o, p1_req_rdy_o}, 2'b00);
         chk("rst_resp_vld", {p0_resp_vld_o, p1_resp_vld_o}, 2'b00);
         chk("rst_resp_data", p0_resp_data_o | p1_resp_data_o, 32'h0);
         @(negedge clk_i);
      end
      p0_req_vld_i   = 1'b0;
      p1_req_vld_i   = 1'b0;
      p0_flush_i     = 1'b0;
      mem_req_rdy_i  = 1'b0;
      mem_resp_vld_i = 1'b0;
      rst_ni         = 1'b1;
      q.delete();
      pref  = 1'b0;
      epoch = 0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      pref  = 1'b0;
      epoch = 0;

      // Both ports streaming, 1-cycle responses: grants alternate 0,1,0,1.
      do_reset(2);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 32'h1000 + i * 8, 1'b1, 32'h8000 + i * 8, 1'b0, 1'b1, 1'b1);
         chk("alt_grant_p1", r_rdy1, i % 2);
         chk("alt_grant_p0", r_rdy0, (i + 1) % 2);
         if (i > 0) begin
            chk("alt_resp_p0", r_resp0, (i - 1) % 2 == 0);
            chk("alt_resp_p1", r_resp1, (i - 1) % 2 == 1);
            chk("alt_resp_data", r_data0,
                (((i - 1) % 2 == 0) ? 32'h1000 + (i - 1) * 8 : 32'h8000 + (i - 1) * 8) ^ KEY);
         end
      end

      // Address alignment.
      do_reset(1);
      cycle(1'b1, 32'h2006, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("addr_align", r_maddr, 32'h2004);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("addr_align_data", r_data0, 32'h2004 ^ KEY);

      // Credit limit: third request held until the first response arrives.
      do_reset(1);
      cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("credit_hold_vld", r_mvld, 1'b0);
      chk("credit_hold_rdy", r_rdy0, 1'b0);
      cycle(1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("credit_release_vld", r_mvld, 1'b1);
      chk("credit_release_rdy", r_rdy0, 1'b1);
      chk("credit_release_resp", r_resp0, 1'b1);

      // Redirect: the two old port-0 responses vanish, the new one arrives.
      do_reset(1);
      cycle(1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h2004, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h3000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      chk("flush_same_cycle_resp", r_resp0, 1'b0);
      chk("flush_new_req_rdy", r_rdy0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("flush_killed_resp", r_resp0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("flush_new_resp", r_resp0, 1'b1);
      chk("flush_new_data", r_data0, 32'h5A5A_3000);

      // Redirect with interleaved tags p1,p0,p1: only port 0 is dropped.
      do_reset(1);
      cycle(1'b0, 32'h0, 1'b1, 32'h4000, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 32'h4010, 1'b1, 1'b1, 1'b1);
      chk("mix_p1_first", r_resp1, 1'b1);
      chk("mix_p1_first_data", r_data1, 32'h5A5A_4000);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("mix_p0_dropped", {r_resp0, r_resp1}, 2'b00);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("mix_p1_second", r_resp1, 1'b1);
      chk("mix_p1_second_data", r_data1, 32'h5A5A_4010);

      // Reset with two requests outstanding.
      do_reset(1);
      cycle(1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h504, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      do_reset(2);
      cycle(1'b1, 32'h600, 1'b1, 32'h700, 1'b0, 1'b1, 1'b0);
      chk("post_rst_vld", r_mvld, 1'b1);
      chk("post_rst_pref_p0", r_rdy0, 1'b1);
      cycle(1'b1, 32'h604, 1'b1, 32'h704, 1'b0, 1'b1, 1'b0);
      chk("post_rst_second", r_rdy1, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if (i % 1000 == 999) do_reset(1);
         cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
